// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED blink controller: display modes, register
// addresses and the divider width.
package led_ctrl_pkg;

  localparam int DIV_W = 8;

  typedef enum logic [1:0] {
    MODE_INDEP = 2'd0,
    MODE_CHASE = 2'd1,
    MODE_SYNC  = 2'd2,
    MODE_OFF   = 2'd3
  } mode_e;

  localparam logic [2:0] ADDR_DIV1 = 3'd0;
  localparam logic [2:0] ADDR_DIV2 = 3'd1;
  localparam logic [2:0] ADDR_DIV3 = 3'd2;
  localparam logic [2:0] ADDR_DIV4 = 3'd3;
  localparam logic [2:0] ADDR_MODE = 3'd4;

  function automatic logic [3:0] chase_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/led_blink_ctrl_tick_gen.sv
// Base tick prescaler: counts 0..CLK_HZ/TICK_HZ-1 and strobes o_Tick on the
// terminal count. i_Clear realigns the tick phase to a display restart.
module tick_gen #(
  parameter int CLK_HZ  = 25000000,
  parameter int TICK_HZ = 100
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Clear,
  output logic o_Tick
);

  localparam int TERM_I = CLK_HZ / TICK_HZ - 1;
  localparam int CW     = (TERM_I < 2) ? 1 : $clog2(TERM_I + 1);
  localparam logic [CW-1:0] TERM = CW'(TERM_I);

  logic [CW-1:0] count_q;

  always_ff @(posedge i_Clk) begin
    if (i_Reset || i_Clear) begin
      count_q <= '0;
    end else if (count_q == TERM) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(1);
    end
  end

  assign o_Tick = (count_q == TERM);

endmodule

// File: rtl/led_blink_ctrl.sv
// Four-LED sequencer: config register file behind a valid/ready write port,
// mode state machine, and per-mode LED/counter update driven by a shared tick.
module led_blink_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int CLK_HZ   = 25000000,
  parameter int TICK_HZ  = 100,
  parameter int DIV1_RST = 5,
  parameter int DIV2_RST = 10,
  parameter int DIV3_RST = 25,
  parameter int DIV4_RST = 50
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Cfg_Valid,
  output logic       o_Cfg_Ready,
  input  logic [2:0] i_Cfg_Addr,
  input  logic [7:0] i_Cfg_Data,
  input  logic       i_Mode_Next,
  output logic [1:0] o_Mode,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4
);

  logic [3:0][DIV_W-1:0] div_q;
  logic [3:0][DIV_W-1:0] cnt_q, cnt_d;
  logic [1:0]            idx_q, idx_d;
  logic [3:0]            led_q, led_d;
  mode_e                 mode_q, mode_d;
  logic                  ready_q;
  logic                  accept, wr_div, wr_mode, restart, tick;

  // Handshake: a write transfers on a clock edge where i_Cfg_Valid and
  // o_Cfg_Ready are both high; the register takes the data on that edge and
  // ready drops for exactly the following cycle.
  assign accept  = i_Cfg_Valid && ready_q;
  assign wr_div  = accept && (i_Cfg_Addr <= ADDR_DIV4);
  assign wr_mode = accept && (i_Cfg_Addr == ADDR_MODE);
  assign restart = wr_div || wr_mode || i_Mode_Next;

  tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick_gen (
    .i_Clk  (i_Clk),
    .i_Reset(i_Reset),
    .i_Clear(restart),
    .o_Tick (tick)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      ready_q <= 1'b1;
      div_q   <= {DIV_W'(DIV4_RST), DIV_W'(DIV3_RST), DIV_W'(DIV2_RST), DIV_W'(DIV1_RST)};
    end else begin
      ready_q <= ~accept;
      if (wr_div) begin
        div_q[i_Cfg_Addr[1:0]] <= i_Cfg_Data;
      end
    end
  end

  // A written mode beats a coincident advance pulse.
  always_comb begin
    mode_d = mode_q;
    if (wr_mode) begin
      mode_d = mode_e'(i_Cfg_Data[1:0]);
    end else if (i_Mode_Next) begin
      mode_d = mode_e'(mode_q + 2'd1);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    led_d = led_q;
    if (restart) begin
      cnt_d = '0;
      idx_d = 2'd0;
      led_d = (mode_d == MODE_CHASE) ? 4'b0001 : 4'b0000;
    end else if (tick) begin
      case (mode_q)
        MODE_INDEP: begin
          for (int i = 0; i < 4; i++) begin
            if (div_q[i] == '0) begin
              led_d[i] = 1'b0;
              cnt_d[i] = '0;
            end else if (cnt_q[i] == div_q[i] - DIV_W'(1)) begin
              led_d[i] = ~led_q[i];
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + DIV_W'(1);
            end
          end
        end
        MODE_CHASE: begin
          if (div_q[0] != '0) begin
            if (cnt_q[0] == div_q[0] - DIV_W'(1)) begin
              cnt_d[0] = '0;
              idx_d    = idx_q + 2'd1;
              led_d    = chase_onehot(idx_q + 2'd1);
            end else begin
              cnt_d[0] = cnt_q[0] + DIV_W'(1);
            end
          end
        end
        MODE_SYNC: begin
          if (div_q[0] == '0) begin
            led_d = 4'b0000;
          end else if (cnt_q[0] == div_q[0] - DIV_W'(1)) begin
            cnt_d[0] = '0;
            led_d    = {4{~led_q[0]}};
          end else begin
            cnt_d[0] = cnt_q[0] + DIV_W'(1);
          end
        end
        default: led_d = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      mode_q <= MODE_INDEP;
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      led_q  <= 4'b0000;
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      led_q  <= led_d;
    end
  end

  assign o_Cfg_Ready = ready_q;
  assign o_Mode      = mode_q;
  assign o_LED_1     = led_q[0];
  assign o_LED_2     = led_q[1];
  assign o_LED_3     = led_q[2];
  assign o_LED_4     = led_q[3];

endmodule

// File: doc/led_blink_ctrl.md
Name: led_blink_ctrl

Overview:
- Controller that schedules four board LEDs from one shared tick prescaler.
- Holds per-LED half-period registers and a display mode register, written through a valid/ready config port.
- A front-panel mode-advance pulse also changes the mode.
- Replaces hard-wired per-LED divider constants with a runtime-configurable sequencer: independent blink, chase, synchronous blink, or off.

Parameters:
- CLK_HZ, 25000000, input clock frequency in Hz.
- TICK_HZ, 100, base tick rate. Prescaler terminal count is CLK_HZ/TICK_HZ-1; the ratio must be an integer ≥ 2.
- DIV1_RST, 5, reset half-period of LED1 in ticks.
- DIV2_RST, 10, reset half-period of LED2 in ticks.
- DIV3_RST, 25, reset half-period of LED3 in ticks.
- DIV4_RST, 50, reset half-period of LED4 in ticks.

Ports:
- i_Clk  in  1  system clock. One clock domain only.
- i_Reset  in  1  synchronous, active-high reset.
- i_Cfg_Valid  in  1  config write request.
- o_Cfg_Ready  out  1  controller can accept a write.
- i_Cfg_Addr  in  3  register address.
- i_Cfg_Data  in  8  write data.
- i_Mode_Next  in  1  single-cycle pulse that advances the mode. Arrives already debounced.
- o_Mode  out  2  current mode.
- o_LED_1..o_LED_4  out  1 each  LED drives, registered.

Behaviour:
- Reset values (i_Reset high at a clock edge):
  - all LEDs 0, o_Mode=0, o_Cfg_Ready=1;
  - prescaler and all tick counters 0, chase index 0;
  - DIVn registers = DIVn_RST.
  - Reset mid-operation discards any in-flight write and any pending restart.
- Tick:
  - Prescaler counts 0..TERM and wraps.
  - tick is a 1-cycle internal strobe on the cycle the count equals TERM.
- Register map:
  - 0..3 = DIV1..DIV4, 8-bit half-period in ticks;
  - 4 = mode, bits[1:0] used, upper bits ignored;
  - 5..7 = write accepted, no effect.
- Handshake:
  - A transfer occurs when i_Cfg_Valid && o_Cfg_Ready at a clock edge (cycle N).
  - Register updates at N+1.
  - o_Cfg_Ready=0 during N+1 and returns to 1 at N+2. Maximum throughput is one write per 2 cycles.
  - i_Cfg_Valid may be held high; the second write is taken at N+2.
- Restart: any accepted write to addr 0..4, or any mode change, restarts the display at N+1.
  - Tick counters and chase index are cleared; the prescaler is also cleared.
  - LEDs are loaded with the mode's initial pattern: CHASE → LED1=1, others 0; all other modes → all 0.
- Mode 0, INDEPENDENT:
  - Each LEDn has an 8-bit counter, advanced on tick.
  - When the counter equals DIVn-1 on tick, LEDn toggles and the counter clears.
  - DIVn=0 holds LEDn at 0.
- Mode 1, CHASE:
  - Exactly one LED is lit.
  - Every DIV1 ticks the lit LED advances 1→2→3→4→1 (2-bit index wraps).
  - DIV1=0 freezes the chase on LED1.
- Mode 2, SYNC:
  - All four LEDs toggle together every DIV1 ticks and stay identical.
  - DIV1=0 holds all at 0.
- Mode 3, OFF: all LEDs 0, counters idle.
- i_Mode_Next:
  - Advances the mode 0→1→2→3→0 and causes a restart.
  - Accepted regardless of o_Cfg_Ready.
- Simultaneous events:
  - A write to addr 4 in the same cycle as i_Mode_Next: the written value wins and the pulse is dropped.
  - A write to addr 0..3 in the same cycle as i_Mode_Next: both take effect, with a single restart.
  - A tick coinciding with a restart is ignored.
- o_Mode always reflects the mode register.
- All outputs are registered; there are no combinational input-to-output paths.

Decomposition:
- Package led_ctrl_pkg holds:
  - mode encodings MODE_INDEP=0, MODE_CHASE=1, MODE_SYNC=2, MODE_OFF=3;
  - register addresses ADDR_DIV1..ADDR_DIV4=0..3, ADDR_MODE=4;
  - the 8-bit divider width constant.
- One sub-module: tick_gen, parameters CLK_HZ/TICK_HZ, with inputs i_Clk, i_Reset, i_Clear and output o_Tick.
- Register file, handshake, restart logic, and mode FSM/LED logic stay in led_blink_ctrl.

Test Plan:
All tests run with CLK_HZ=100 and TICK_HZ=10 (tick every 10 cycles).
1. Reset, then run 1000 cycles in mode 0 → LED1 toggles every 50 cycles, LED2 every 100, LED3 every 250, LED4 every 500; o_Mode=0.
2. Write addr 4 data 0x01, then DIV1=2 via addr 0 → o_Cfg_Ready low exactly 1 cycle after each write. One LED is lit at all times, advancing every 20 cycles in order 1,2,3,4,1.
3. Hold i_Cfg_Valid high for 3 back-to-back writes (addr 1=3, addr 2=0, addr 4=2) → accepted on alternate cycles. Mode SYNC; all LEDs identical, toggling every 50 cycles. The addr 2=0 write has no visible effect in SYNC.
4. Pulse i_Mode_Next four times from mode 0 → o_Mode sequence 1,2,3,0; in mode 3 all LEDs 0.
5. Drive i_Mode_Next in the same cycle as a write of addr 4=3 → o_Mode=3, not 1; exactly one restart.
6. Assert i_Reset in the cycle after a write is accepted, while o_Cfg_Ready is low → next cycle: o_Cfg_Ready=1, DIVn back to reset values, all LEDs 0, o_Mode=0.
